mem_dma: RTL

//   Initiator for the 8-bit single-port data memory interface: a byte-copy engine.
//   - Copies len bytes from src to dst, one byte per two cycles.
//   - Sits beside the CPU and drives the memory's address/write_data/wren bus while busy.
//   - The CPU arbitrates the bus using busy.

---
 rtl/mem_dma_pkg.sv | 17 +
 rtl/mem_dma_ctr.sv | 34 +++
 rtl/mem_dma.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared definitions for the mem_dma byte-copy engine.
//   - Default widths for address, data and length.
//   - FSM state encodings (2-bit): ST_IDLE, ST_READ, ST_WRITE, ST_DONE.
package mem_dma_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int LW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_dma_ctr.sv
// mem_dma_ctr: byte index counter for the mem_dma engine.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clr       - clear the index to 0 (takes priority over inc)
//   inc       - advance the index by one
//   len       - captured transfer length, used for the last flag
//   idx       - current byte index
//   last      - high when idx+1 == len, i.e. the current byte is the final one
module mem_dma_ctr #(
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [LW-1:0] len,
  output logic [LW-1:0] idx,
  output logic          last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + LW'(1);
    end
  end

  // Compared in LW bits so the flag matches the wrapped index arithmetic.
  assign last = ((idx + LW'(1)) == len);

endmodule

// File: rtl/mem_dma.sv
// mem_dma: byte-copy initiator for the 8-bit single-port data memory.
// Copies len bytes from src to dst in strict forward order, one byte every
// two cycles (READ then WRITE). The CPU uses busy to arbitrate the bus.
// Build option: define MEM_DMA_FILL_EN to add a fill mode (fill, fill_value)
// that skips READ and writes fill_value at one byte per cycle.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - one-cycle request, only accepted in IDLE
//   src, dst, len   - transfer descriptor, captured on accepted start
//   fill, fill_value- (MEM_DMA_FILL_EN only) fill request and byte value
//   busy            - high while in READ/WRITE
//   done            - one-cycle completion pulse
//   mem_address     - memory address
//   mem_write_data  - memory write data
//   mem_wren        - active-low write strobe
//   mem_read_data   - combinational read data for mem_address
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
`ifdef MEM_DMA_FILL_EN
  input  logic          fill,
  input  logic [DW-1:0] fill_value,
`endif
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_read_data
);

  state_t        state_q;
  state_t        state_d;

  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [LW-1:0] len_q;
  logic [DW-1:0] data_q;
  logic [LW-1:0] idx;
  logic          last;

  logic          start_acc;
  logic          fill_req;
  logic          fill_run;
  logic [DW-1:0] wr_val;

  // Address arithmetic wraps modulo 2^AW.
  function automatic logic [AW-1:0] addr_add(input logic [AW-1:0] base,
                                             input logic [LW-1:0] off);
    return base + AW'(off);
  endfunction

  assign start_acc = (state_q == ST_IDLE) && start;

`ifdef MEM_DMA_FILL_EN
  logic          fill_q;
  logic [DW-1:0] fill_value_q;

  always_ff @(posedge clk) begin
    if (start_acc) begin
      fill_q       <= fill;
      fill_value_q <= fill_value;
    end
  end

  assign fill_req = fill;
  assign fill_run = fill_q;
  assign wr_val   = fill_q ? fill_value_q : data_q;
`else
  assign fill_req = 1'b0;
  assign fill_run = 1'b0;
  assign wr_val   = data_q;
`endif

  // Descriptor and data registers carry no reset; they are only consumed
  // in states reachable after an accepted start has loaded them.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      src_q <= src;
      dst_q <= dst;
      len_q <= len;
    end
    if (state_q == ST_READ) begin
      data_q <= mem_read_data;
    end
  end

  mem_dma_ctr #(
    .LW(LW)
  ) u_ctr (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .inc (state_q == ST_WRITE),
    .len (len_q),
    .idx (idx),
    .last(last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = ST_DONE;
          end else if (fill_req) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: begin
        if (last) begin
          state_d = ST_DONE;
        end else if (fill_run) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decode only registered state, so start never reaches mem_*.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    mem_wren       = 1'b1;
    mem_address    = '0;
    mem_write_data = '0;
    case (state_q)
      ST_READ: begin
        busy        = 1'b1;
        mem_address = addr_add(src_q, idx);
      end
      ST_WRITE: begin
        busy           = 1'b1;
        mem_address    = addr_add(dst_q, idx);
        mem_write_data = wr_val;
        mem_wren       = 1'b0;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
